// File: rtl/stepper_pkg.sv
// Shared types for the stepper sequencer: FSM states, phase index width and coil table.
// Coil vectors are packed {ina, inb, ina2, inb2}.
package stepper_pkg;

    localparam int PH_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef logic [3:0] coil_t;

    function automatic coil_t phase_coils(input logic [PH_W-1:0] p);
        coil_t c;
        case (p)
            3'd0:    c = 4'b1000;
            3'd1:    c = 4'b1100;
            3'd2:    c = 4'b0100;
            3'd3:    c = 4'b0110;
            3'd4:    c = 4'b0010;
            3'd5:    c = 4'b0011;
            3'd6:    c = 4'b0001;
            default: c = 4'b1001;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/stepper_seq_if.sv
// Command and coil-drive bundle between the strobe logic, the sequencer and the H-bridge pins.
interface stepper_seq_if #(
    parameter int STEPS_W = 16,
    parameter int DIV_W   = 24,
    parameter int POS_W   = 16,
    parameter int PWM_W   = 8
);
    logic               stb;
    logic               abort;
    logic               dir;
    logic               half;
    logic [STEPS_W-1:0] steps;
    logic [DIV_W-1:0]   period;
    logic [PWM_W-1:0]   duty;
    logic               ina;
    logic               inb;
    logic               ina2;
    logic               inb2;
    logic               busy;
    logic               done;
    logic [POS_W-1:0]   pos;

    modport master (
        output stb, abort, dir, half, steps, period, duty,
        input  ina, inb, ina2, inb2, busy, done, pos
    );

    modport slave (
        input  stb, abort, dir, half, steps, period, duty,
        output ina, inb, ina2, inb2, busy, done, pos
    );
endinterface

// File: rtl/stepper_timer.sv
// Loadable step-period down-counter; tc pulses while enabled at count 1 and the counter reloads.
// Load has priority over counting; a count of 0 is treated like 1.
module stepper_timer #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [DIV_W-1:0] load_val,
    input  logic [DIV_W-1:0] reload_val,
    output logic             tc
);
    logic [DIV_W-1:0] cnt;

    assign tc = en && (cnt <= DIV_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= tc ? reload_val : cnt - DIV_W'(1);
        end
    end
endmodule

// File: rtl/stepper_seq.sv
// 4-coil full/half-step sequencer with abort, busy/done and signed position; coil outputs registered.
// Optional STEPPER_PWM_EN gates energised coils with a free-running duty counter.
module stepper_seq
    import stepper_pkg::*;
#(
    parameter int STEPS_W = 16,
    parameter int DIV_W   = 24,
    parameter int POS_W   = 16,
    parameter int HOLD_EN = 1,
    parameter int PWM_W   = 8
) (
    input logic          clk,
    input logic          rst_n,
    stepper_seq_if.slave bus
);
    state_t             state, state_d;
    logic               stb_q;
    logic [PH_W-1:0]    p, p_d;
    logic [POS_W-1:0]   pos, pos_d;
    logic [STEPS_W-1:0] rem, rem_d;
    logic               dir_l, half_l;
    logic [DIV_W-1:0]   period_l, period_fix;
    logic               stepped, stepped_d;
    logic               done, done_d;
    coil_t              coils, coil_d;
    logic               start, step, timer_load, timer_en, gate;
    logic [1:0]         delta;

    assign start      = bus.stb && !stb_q;
    assign period_fix = (bus.period == '0) ? DIV_W'(1) : bus.period;
    assign timer_load = (state == IDLE) && start;
    assign timer_en   = (state == RUN) && !bus.abort;
    // Full-step from an even phase moves only one index to land on a two-coil phase.
    assign delta      = (half_l || !p[0]) ? 2'd1 : 2'd2;

    stepper_timer #(.DIV_W(DIV_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .en         (timer_en),
        .load_val   (period_fix),
        .reload_val (period_l),
        .tc         (step)
    );

`ifdef STEPPER_PWM_EN
    logic [PWM_W-1:0] pwm_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_cnt <= '0;
        else        pwm_cnt <= pwm_cnt + PWM_W'(1);
    end

    assign gate = (pwm_cnt < bus.duty);
`else
    logic [PWM_W-1:0] unused_duty;
    assign unused_duty = bus.duty;
    assign gate        = 1'b1;
`endif

    always_comb begin
        state_d   = state;
        p_d       = p;
        pos_d     = pos;
        rem_d     = rem;
        stepped_d = stepped;
        done_d    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    rem_d = bus.steps;
                    if (bus.steps == '0) done_d  = 1'b1;
                    else                 state_d = RUN;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    rem_d   = '0;
                end else if (step) begin
                    p_d       = dir_l ? p + PH_W'(delta) : p - PH_W'(delta);
                    pos_d     = dir_l ? pos + POS_W'(delta) : pos - POS_W'(delta);
                    rem_d     = rem - STEPS_W'(1);
                    stepped_d = 1'b1;
                    if (rem == STEPS_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Idle hold only after a real step, so coils stay dark from reset until motion.
        if (state_d == RUN || (HOLD_EN != 0 && stepped_d)) coil_d = phase_coils(p_d) & {4{gate}};
        else                                              coil_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            stb_q    <= 1'b0;
            p        <= '0;
            pos      <= '0;
            rem      <= '0;
            dir_l    <= 1'b0;
            half_l   <= 1'b0;
            period_l <= DIV_W'(1);
            stepped  <= 1'b0;
            done     <= 1'b0;
            coils    <= '0;
        end else begin
            state   <= state_d;
            stb_q   <= bus.stb;
            p       <= p_d;
            pos     <= pos_d;
            rem     <= rem_d;
            stepped <= stepped_d;
            done    <= done_d;
            coils   <= coil_d;
            if (timer_load) begin
                dir_l    <= bus.dir;
                half_l   <= bus.half;
                period_l <= period_fix;
            end
        end
    end

    assign {bus.ina, bus.inb, bus.ina2, bus.inb2} = coils;
    assign bus.busy = (state == RUN);
    assign bus.done = done;
    assign bus.pos  = pos;
endmodule

// File: tb/tb_stepper_seq.sv
// Directed bench: expected step/done events are queued at stimulus time and checked by a monitor.
module tb_stepper_seq;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    stepper_seq_if #(.STEPS_W(16), .DIV_W(24), .POS_W(16), .PWM_W(8)) bus1 ();
    stepper_seq_if #(.STEPS_W(16), .DIV_W(24), .POS_W(16), .PWM_W(8)) bus2 ();

    assign bus2.stb    = bus1.stb;
    assign bus2.abort  = bus1.abort;
    assign bus2.dir    = bus1.dir;
    assign bus2.half   = bus1.half;
    assign bus2.steps  = bus1.steps;
    assign bus2.period = bus1.period;
    assign bus2.duty   = bus1.duty;

    stepper_seq #(.STEPS_W(16), .DIV_W(24), .POS_W(16), .HOLD_EN(1), .PWM_W(8)) dut_hold (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    stepper_seq #(.STEPS_W(16), .DIV_W(24), .POS_W(16), .HOLD_EN(0), .PWM_W(8)) dut_nohold (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave));

    typedef struct {
        logic [3:0]  coils;
        logic [15:0] pos;
        logic        done;
        int          gap;
    } evt_t;

    evt_t        sb[$];
    int          n_cmp = 0;
    int          n_mis = 0;
    logic [2:0]  p_m;
    logic [15:0] pos_m;
    bit          mon_en = 1'b0;
    int          since = 0;
    logic        busy_prev = 1'b0;
    logic [15:0] pos_prev = '0;

    wire [3:0] coils1 = {bus1.ina, bus1.inb, bus1.ina2, bus1.inb2};
    wire [3:0] coils2 = {bus2.ina, bus2.inb, bus2.ina2, bus2.inb2};

    function automatic logic [3:0] tbl(input logic [2:0] p);
        case (p)
            3'd0: return 4'b1000;  3'd1: return 4'b1100;
            3'd2: return 4'b0100;  3'd3: return 4'b0110;
            3'd4: return 4'b0010;  3'd5: return 4'b0011;
            3'd6: return 4'b0001;  default: return 4'b1001;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit half, input bit dir);
        logic [2:0] d;
        d = (half || !p_m[0]) ? 3'd1 : 3'd2;
        p_m   = dir ? p_m + d : p_m - d;
        pos_m = dir ? pos_m + 16'(d) : pos_m - 16'(d);
    endtask

    task automatic push_move(input bit half, input bit dir, input int n, input int gap, input bit last_done);
        for (int i = 0; i < n; i++) begin
            model_step(half, dir);
            sb.push_back('{tbl(p_m), pos_m, last_done && (i == n - 1), gap});
        end
    endtask

    task automatic start_move(input bit half, input bit dir, input logic [15:0] steps, input logic [23:0] period);
        @(negedge clk);
        bus1.half = half; bus1.dir = dir; bus1.steps = steps; bus1.period = period;
        bus1.stb  = 1'b1;
        @(negedge clk);
        bus1.stb  = 1'b0;
    endtask

    task automatic wait_drain(input int limit, output int busy_cycles);
        busy_cycles = bus1.busy ? 1 : 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus1.busy) busy_cycles++;
            if (sb.size() == 0 && !bus1.busy) break;
        end
        chk("drain_timeout", sb.size(), 0);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        p_m = '0; pos_m = '0;
        @(negedge clk);
        mon_en = 1'b1;
    endtask

    always @(negedge clk) begin
        evt_t e;
        since++;
        if (bus1.busy && !busy_prev) since = 0;
        if (mon_en && rst_n && (bus1.pos !== pos_prev || bus1.done)) begin
            chk("evt_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
`ifndef STEPPER_PWM_EN
                chk("coils", coils1, e.coils);
                chk("coils_nohold", coils2, e.done ? 4'b0000 : e.coils);
`endif
                chk("pos", bus1.pos, e.pos);
                chk("pos_nohold", bus2.pos, e.pos);
                chk("done", bus1.done, e.done);
                if (e.gap >= 0) chk("gap", since, e.gap);
            end
            since = 0;
        end
        busy_prev = bus1.busy;
        pos_prev  = bus1.pos;
    end

    initial begin
        int bc;
        int dc;
        logic [3:0] c_before;
        logic [15:0] pos_before;
        rst_n = 1'b0;
        bus1.stb = 0; bus1.abort = 0; bus1.dir = 0; bus1.half = 0;
        bus1.steps = '0; bus1.period = '0; bus1.duty = 8'hFF;
        p_m = '0; pos_m = '0;

        @(negedge clk);
        chk("rst_coils", coils1, 4'b0000);
        chk("rst_busy", bus1.busy, 0);
        chk("rst_done", bus1.done, 0);
        chk("rst_pos", bus1.pos, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        // Half-step forward through a full revolution.
        push_move(1'b1, 1'b1, 8, 5, 1'b1);
        start_move(1'b1, 1'b1, 16'd8, 24'd5);
        wait_drain(200, bc);
        chk("busy_len_t1", bc, 40);
        chk("pos_t1", bus1.pos, 16'd8);
        chk("hold_idle", coils1, tbl(3'd0));
        chk("nohold_idle", coils2, 4'b0000);

        // Full-step reverse from phase 0: first step realigns to odd.
        do_reset();
        push_move(1'b0, 1'b0, 3, 2, 1'b1);
        start_move(1'b0, 1'b0, 16'd3, 24'd2);
        wait_drain(100, bc);
        chk("pos_t2", bus1.pos, 16'hFFFB);

        // PERIOD of zero behaves as one cycle per step.
        push_move(1'b1, 1'b1, 2, 1, 1'b1);
        start_move(1'b1, 1'b1, 16'd2, 24'd0);
        wait_drain(50, bc);
        chk("busy_len_p0", bc, 2);

        // Zero-step command: DONE only.
        c_before = coils1; pos_before = bus1.pos;
        sb.push_back('{c_before, pos_before, 1'b1, -1});
        start_move(1'b1, 1'b0, 16'd0, 24'd4);
        wait_drain(20, bc);
        chk("busy_len_s0", bc, 0);
        chk("coils_s0", coils1, c_before);

        // Long move aborted after three steps; a stray STB in RUN must not restart timing.
        push_move(1'b1, 1'b1, 3, 10, 1'b0);
        sb.push_back('{tbl(p_m), pos_m, 1'b1, 5});
        start_move(1'b1, 1'b1, 16'd100, 24'd10);
        repeat (14) @(negedge clk);
        @(negedge clk); bus1.stb = 1'b1;
        @(negedge clk); bus1.stb = 1'b0;
        repeat (18) @(negedge clk);
        bus1.abort = 1'b1;
        @(negedge clk);
        bus1.abort = 1'b0;
        chk("busy_after_abort", bus1.busy, 0);
        repeat (30) @(negedge clk);
        chk("sb_after_abort", sb.size(), 0);
        chk("pos_after_abort", bus1.pos, pos_m);

`ifdef STEPPER_PWM_EN
        bus1.duty = 8'd64;
        repeat (2) @(negedge clk);
        dc = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (coils1 != 4'b0000) dc++;
        end
        chk("pwm_duty64", dc, 64);
        bus1.duty = 8'd0;
        repeat (2) @(negedge clk);
        dc = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (coils1 != 4'b0000) dc++;
        end
        chk("pwm_duty0", dc, 0);
        bus1.duty = 8'hFF;
`endif

        // Reset in the middle of a move.
        mon_en = 1'b0;
        start_move(1'b1, 1'b1, 16'd50, 24'd3);
        repeat (10) @(negedge clk);
        chk("busy_mid", bus1.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_coils", coils1, 4'b0000);
        chk("midrst_pos", bus1.pos, 16'h0000);
        chk("midrst_busy", bus1.busy, 0);
        chk("midrst_done", bus1.done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus1.done || bus2.done) dc++;
        end
        chk("midrst_no_done", dc, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/stepper_seq.md
Name: stepper_seq

Overview:
Parametrised 4-coil stepper sequencer. It drives INA/INB/INA2/INB2 through full-step or half-step phase tables, with programmable direction, step count and step period. It replaces the fixed single-mode motor mover and adds an abort input, busy/done status and a signed position counter. It sits between the command/strobe logic and the H-bridge pins.

Parameters:
STEPS_W, 16, width of the requested step count.
DIV_W, 24, width of the step-period counter, in CLK cycles.
POS_W, 16, width of the signed position counter, in half-step units.
HOLD_EN, 1, 1: coils keep the last phase while idle; 0: coils are de-energised while idle.
PWM_W, 8, width of the duty input and the PWM counter (used only with the optional feature).

Ports:
CLK  in  1  system clock.
RST_N  in  1  asynchronous active-low reset.
STB  in  1  start strobe, synchronous to CLK; acted on at its rising edge.
ABORT  in  1  stops a move in progress.
DIR  in  1  direction: 1 = phase index increments, 0 = phase index decrements.
HALF  in  1  1 = half-step, 0 = full-step (two coils on).
STEPS  in  STEPS_W  number of steps to execute.
PERIOD  in  DIV_W  CLK cycles per step; a value of 0 is treated as 1.
DUTY  in  PWM_W  coil duty cycle; ignored unless STEPPER_PWM_EN is defined.
INA, INB, INA2, INB2  out  1 each  coil drive outputs.
BUSY  out  1  high while a move is running.
DONE  out  1  one-cycle pulse when a move finishes or is aborted.
POS  out  POS_W  signed position in half-step units; two's complement, wraps modulo 2^POS_W.

Behaviour:
- Reset (asynchronous, RST_N=0):
  - state IDLE; phase index p=0; POS=0.
  - BUSY=0, DONE=0, all coil outputs 0.
  - The coils stay at 0 until the first step after reset, even when HOLD_EN=1.
- Phase table for p = 0..7, coils listed as energised: 0:A; 1:A,B; 2:B; 3:B,A2; 4:A2; 5:A2,B2; 6:B2; 7:B2,A.
- STB edge detection: a registered copy of STB; a rising edge is STB=1 with the previous value 0.
- IDLE: on a rising edge of STB:
  - latch DIR, HALF, STEPS and PERIOD (PERIOD=0 becomes 1);
  - load the step timer with PERIOD;
  - set remaining = STEPS.
  - If STEPS=0: DONE=1 on the next cycle, no motion, stay IDLE, BUSY stays 0.
  - Otherwise go to RUN; BUSY=1 from the next cycle.
  - STB edges seen while in RUN are ignored.
- RUN:
  - The timer decrements every cycle. When it reaches 1, one step executes and the timer reloads with the latched PERIOD.
  - The first coil change appears PERIOD cycles after BUSY rises; later steps are exactly PERIOD cycles apart.
- Step size:
  - HALF=1: p moves by ±1 (modulo 8), and POS moves by ±1.
  - HALF=0: p moves by ±2 and POS by ±2.
  - Exception for HALF=0: if p is even when the step executes, this step moves p and POS by ±1 only, which realigns the index to an odd phase. It counts as one step.
- remaining decrements on each step. On the step where it reaches 0:
  - the next cycle goes to IDLE, DONE=1 for one cycle, and BUSY=0 in that same cycle.
- ABORT=1 in RUN:
  - the next cycle goes to IDLE with DONE=1 and BUSY=0; remaining is cleared.
  - No step executes in the cycle ABORT is sampled, even if the timer expires in that cycle.
  - ABORT in IDLE is ignored.
- Idle coils: HOLD_EN=1 drives the table entry for p; HOLD_EN=0 drives all 0s.
- While BUSY=1 the coils always show the table entry for p.
- Coil outputs are registered; they never glitch through intermediate table entries.
- POS wraps silently, e.g. 0x7FFF + 1 becomes 0x8000.
- Reset mid-move: everything returns immediately to the reset values; no DONE pulse.

Optional Feature:
- Macro STEPPER_PWM_EN.
- Defined:
  - a free-running PWM_W-bit counter gates the coil outputs; energised coils are high only while counter < DUTY.
  - DUTY=0 forces all coils off; DUTY=2^PWM_W−1 gives 255/256 duty at the default width.
  - The gating applies in RUN and in idle hold.
- Not defined: no PWM counter exists, DUTY is unused, and the coils follow the phase table directly.

Decomposition:
- Package stepper_pkg holds:
  - state enum IDLE/RUN;
  - the 8-entry phase table constant, packed as {INA,INB,INA2,INB2};
  - the phase index width (3).
- One sub-module, stepper_timer: loadable down-counter with reload and a terminal-count pulse, parametrised by DIV_W.
- The PWM gate stays inline in stepper_seq.

Test Plan:
- Reset, then STB with HALF=1, DIR=1, STEPS=8, PERIOD=5 → coils cycle through phases 1..7 then 0, 5 cycles apart; POS=8; one DONE pulse; BUSY high for 40 cycles.
- From p=0: HALF=0, DIR=0, STEPS=3, PERIOD=2 → p goes 7, 5, 3; POS=−5 (0xFFFB); DONE once.
- STEPS=0 → DONE pulse only; coils, POS and BUSY unchanged.
- STEPS=100, PERIOD=10, ABORT raised 35 cycles after BUSY rises → exactly 3 steps; DONE on the next cycle; BUSY=0; an STB edge during the run is ignored.
- HOLD_EN=0 after a move → all coils 0 while idle. Assert RST_N low mid-move → outputs 0 immediately, POS=0, no DONE.
- With STEPPER_PWM_EN defined, DUTY=64, PWM_W=8 → each energised coil is high 64 of every 256 cycles; DUTY=0 → all coils off.
